led_seq_ctrl: RTL and testbench



---
 rtl/led_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl -- sequencing controller for the one-hot LED position bank.
//
// Takes the debounced left/right button levels and turns them into events.
// A single press opens a short chord window. A press of the other button
// inside that window commits a CHORD; otherwise SINGLE(first button) commits
// when the window expires. Events step the LED manually, or switch between
// MANUAL and timer-driven auto rotation (AUTO_R / AUTO_L).
//
// Optional build macro: LED_SEQ_SPEED_EN. When it is defined, a same-direction
// SINGLE in an AUTO state bumps a 2-bit speed that halves the auto period per
// step. When it is undefined, the speed stays fixed at 0.
//
// Parameters:
//   WIDTH      LED count / rotation width (>= 2)
//   CHORD_WIN  cycles a first press waits for its partner (>= 2)
//   TICK_DIV   auto-step period in cycles at speed 0 (>= 8)
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   left   in   debounced left level, active high
//   right  in   debounced right level, active high
//   led    out  WIDTH-bit one-hot position (registered)
//   mode   out  00 MANUAL, 01 AUTO_R, 10 AUTO_L (registered)
//   busy   out  chord window open (registered)
module led_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter int CHORD_WIN = 1_200_000,
    parameter int TICK_DIV  = 12_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left,
    input  logic             right,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode,
    output logic             busy
);

    localparam int WIN_W  = $clog2(CHORD_WIN);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHORD_WIN - 1);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO_R = 2'b01;
    localparam logic [1:0] MODE_AUTO_L = 2'b10;

    logic              left_q_r, right_q_r;
    logic              left_press_s, right_press_s;
    logic              busy_r, busy_nxt_s;
    logic              first_right_r, first_right_nxt_s;
    logic [WIN_W-1:0]  win_cnt_r, win_cnt_nxt_s;
    logic              commit_single_s, commit_chord_s;
    logic [1:0]        mode_r, mode_nxt_s;
    logic [WIDTH-1:0]  led_r, led_nxt_s;
    logic [WIDTH-1:0]  rot_right_s, rot_left_s;
    logic [TICK_W-1:0] tick_cnt_r, tick_nxt_s;
    logic [TICK_W-1:0] tick_last_s;
    logic [31:0]       period_s;
    logic [1:0]        speed_s;
`ifdef LED_SEQ_SPEED_EN
    logic [1:0]        speed_r, speed_nxt_s;
    assign speed_s = speed_r;
`else
    assign speed_s = 2'b00;
`endif

    // The _q registers reset to 1 so a button held through reset is not a press.
    assign left_press_s  = left  & ~left_q_r;
    assign right_press_s = right & ~right_q_r;

    assign rot_right_s = {led_r[0], led_r[WIDTH-1:1]};
    assign rot_left_s  = {led_r[WIDTH-2:0], led_r[WIDTH-1]};

    assign period_s    = 32'(TICK_DIV) >> speed_s;
    assign tick_last_s = TICK_W'(period_s - 32'd1);

    // Chord window arbitration: opens on a first press, commits CHORD or SINGLE.
    always_comb begin
        busy_nxt_s        = busy_r;
        first_right_nxt_s = first_right_r;
        win_cnt_nxt_s     = win_cnt_r;
        commit_single_s   = 1'b0;
        commit_chord_s    = 1'b0;
        if (!busy_r) begin
            if (left_press_s && right_press_s) begin
                commit_chord_s = 1'b1;
            end else if (left_press_s || right_press_s) begin
                busy_nxt_s        = 1'b1;
                win_cnt_nxt_s     = {WIN_W{1'b0}};
                first_right_nxt_s = right_press_s;
            end else begin
                win_cnt_nxt_s = {WIN_W{1'b0}};
            end
        end else begin
            // Partner press beats expiry, so a chord in the last window cycle still counts.
            if ((first_right_r && left_press_s) || (!first_right_r && right_press_s)) begin
                commit_chord_s = 1'b1;
                busy_nxt_s     = 1'b0;
                win_cnt_nxt_s  = {WIN_W{1'b0}};
            end else if (win_cnt_r == WIN_LAST) begin
                commit_single_s = 1'b1;
                busy_nxt_s      = 1'b0;
                win_cnt_nxt_s   = {WIN_W{1'b0}};
            end else begin
                win_cnt_nxt_s = win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Event actions and auto tick; a commit always wins over a same-cycle wrap.
    always_comb begin
        mode_nxt_s = mode_r;
        led_nxt_s  = led_r;
        tick_nxt_s = tick_cnt_r;
`ifdef LED_SEQ_SPEED_EN
        speed_nxt_s = speed_r;
`endif
        if (commit_chord_s || commit_single_s) begin
            tick_nxt_s = {TICK_W{1'b0}};
            case (mode_r)
                MODE_MANUAL: begin
                    if (commit_chord_s) begin
                        mode_nxt_s = MODE_AUTO_R;
                    end else if (first_right_r) begin
                        led_nxt_s = rot_right_s;
                    end else begin
                        led_nxt_s = rot_left_s;
                    end
                end
                MODE_AUTO_R, MODE_AUTO_L: begin
                    if (commit_chord_s) begin
                        mode_nxt_s = MODE_MANUAL;
`ifdef LED_SEQ_SPEED_EN
                        speed_nxt_s = 2'b00;
`endif
                    end else if (first_right_r != (mode_r == MODE_AUTO_R)) begin
                        // Opposite-direction press reverses rotation.
                        mode_nxt_s = first_right_r ? MODE_AUTO_R : MODE_AUTO_L;
                    end else begin
`ifdef LED_SEQ_SPEED_EN
                        speed_nxt_s = speed_r + 2'b01;
`else
                        // Same-direction press only restarts the period.
                        tick_nxt_s = {TICK_W{1'b0}};
`endif
                    end
                end
                default: begin
                    mode_nxt_s = MODE_MANUAL;
                end
            endcase
        end else if (mode_r != MODE_MANUAL) begin
            if (tick_cnt_r == tick_last_s) begin
                tick_nxt_s = {TICK_W{1'b0}};
                led_nxt_s  = (mode_r == MODE_AUTO_R) ? rot_right_s : rot_left_s;
            end else begin
                tick_nxt_s = tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
            end
        end else begin
            tick_nxt_s = {TICK_W{1'b0}};
        end
    end

    // State registers; reset aborts any open window and pending tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q_r      <= 1'b1;
            right_q_r     <= 1'b1;
            busy_r        <= 1'b0;
            first_right_r <= 1'b0;
            win_cnt_r     <= {WIN_W{1'b0}};
            mode_r        <= MODE_MANUAL;
            led_r         <= {{(WIDTH-1){1'b0}}, 1'b1};
            tick_cnt_r    <= {TICK_W{1'b0}};
`ifdef LED_SEQ_SPEED_EN
            speed_r       <= 2'b00;
`endif
        end else begin
            left_q_r      <= left;
            right_q_r     <= right;
            busy_r        <= busy_nxt_s;
            first_right_r <= first_right_nxt_s;
            win_cnt_r     <= win_cnt_nxt_s;
            mode_r        <= mode_nxt_s;
            led_r         <= led_nxt_s;
            tick_cnt_r    <= tick_nxt_s;
`ifdef LED_SEQ_SPEED_EN
            speed_r       <= speed_nxt_s;
`endif
        end
    end

    assign led  = led_r;
    assign mode = mode_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl (WIDTH=4, CHORD_WIN=4, TICK_DIV=16).
// Expected {led, mode, busy} values are queued with the cycle in which they
// must be visible; a negedge monitor compares and retires them.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left;
    logic       right;
    logic [3:0] led;
    logic [1:0] mode;
    logic       busy;

`ifdef LED_SEQ_SPEED_EN
    localparam bit SPEED_EN = 1'b1;
`else
    localparam bit SPEED_EN = 1'b0;
`endif

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         c;
        logic [6:0] v;
        string      tag;
    } exp_t;
    exp_t sb_q[$];

    led_seq_ctrl #(.WIDTH(4), .CHORD_WIN(4), .TICK_DIV(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .left  (left),
        .right (right),
        .led   (led),
        .mode  (mode),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [6:0] got;
        got = {led, mode, busy};
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].c <= cyc) begin
                vectors++;
                assert (got === sb_q[i].v && sb_q[i].c == cyc) else begin
                    miscompares++;
                    $error("FAIL %s cyc=%0d observed led/mode/busy=%b expected=%b (due cyc %0d)",
                           sb_q[i].tag, cyc, got, sb_q[i].v, sb_q[i].c);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] l, input logic [1:0] m,
                        input logic b, input string tag);
        exp_t e;
        e.c = c;
        e.v = {l, m, b};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        left  = 1'b1;
        right = 1'b0;

        // Reset with left held: no event until released and re-pressed.
        push(1, 4'b0001, 2'b00, 1'b0, "reset_values");
        push(4, 4'b0001, 2'b00, 1'b0, "held_left_no_event");
        push(9, 4'b0001, 2'b00, 1'b0, "release_no_event");
        goto(2);  rst_n = 1'b1;
        goto(7);  left = 1'b0;

        // Single right press at 10 (repeat press at 12 ignored), then left press.
        push(11, 4'b0001, 2'b00, 1'b1, "single_r_busy_first");
        push(14, 4'b0001, 2'b00, 1'b1, "single_r_busy_last");
        push(15, 4'b1000, 2'b00, 1'b0, "single_r_commit");
        push(22, 4'b1000, 2'b00, 1'b1, "single_l_busy_last");
        push(23, 4'b0001, 2'b00, 1'b0, "single_l_commit");
        goto(10); right = 1'b1;
        goto(11); right = 1'b0;
        goto(12); right = 1'b1;
        goto(13); right = 1'b0;
        goto(18); left = 1'b1;
        goto(19); left = 1'b0;

        // Chord left@30 + right@32 -> AUTO_R, steps visible at 49 and 65.
        push(32, 4'b0001, 2'b00, 1'b1, "chord_window_open");
        push(33, 4'b0001, 2'b01, 1'b0, "chord_to_auto_r");
        push(48, 4'b0001, 2'b01, 1'b0, "auto_r_before_step1");
        push(49, 4'b1000, 2'b01, 1'b0, "auto_r_step1");
        push(64, 4'b1000, 2'b01, 1'b0, "auto_r_before_step2");
        push(65, 4'b0100, 2'b01, 1'b0, "auto_r_step2");
        goto(30); left = 1'b1;
        goto(31); left = 1'b0;
        goto(32); right = 1'b1;
        goto(33); right = 1'b0;

        // Left single in AUTO_R at 70 -> AUTO_L at 75, first step visible at 91.
        push(74, 4'b0100, 2'b01, 1'b1, "auto_r_window");
        push(75, 4'b0100, 2'b10, 1'b0, "to_auto_l");
        push(90, 4'b0100, 2'b10, 1'b0, "auto_l_before_step");
        push(91, 4'b1000, 2'b10, 1'b0, "auto_l_step1");
        goto(70); left = 1'b1;
        goto(71); left = 1'b0;

        // Same-direction left press at 95, commit at 99: speed 1 or unchanged.
        push(100, 4'b1000, 2'b10, 1'b0, "same_dir_commit");
        push(107, 4'b1000, 2'b10, 1'b0, "same_dir_107");
        push(108, SPEED_EN ? 4'b0001 : 4'b1000, 2'b10, 1'b0, "same_dir_108");
        push(115, SPEED_EN ? 4'b0001 : 4'b1000, 2'b10, 1'b0, "same_dir_115");
        push(116, SPEED_EN ? 4'b0010 : 4'b0001, 2'b10, 1'b0, "same_dir_116");
        goto(95); left = 1'b1;
        goto(96); left = 1'b0;

        // Both buttons in one cycle in AUTO_L -> MANUAL, led frozen.
        push(121, SPEED_EN ? 4'b0010 : 4'b0001, 2'b00, 1'b0, "dual_chord_manual");
        push(170, SPEED_EN ? 4'b0010 : 4'b0001, 2'b00, 1'b0, "manual_frozen_170");
        push(221, SPEED_EN ? 4'b0010 : 4'b0001, 2'b00, 1'b0, "manual_frozen_221");
        goto(120); left = 1'b1; right = 1'b1;
        goto(121); left = 1'b0; right = 1'b0;

        // Chord partner in the final window cycle still counts.
        push(234, SPEED_EN ? 4'b0010 : 4'b0001, 2'b00, 1'b1, "last_win_cycle");
        push(235, SPEED_EN ? 4'b0010 : 4'b0001, 2'b01, 1'b0, "last_win_chord");
        goto(230); left = 1'b1;
        goto(231); left = 1'b0;
        goto(234); right = 1'b1;
        goto(235); right = 1'b0;

        // Reset mid-window aborts the pending event and the tick period.
        push(241, SPEED_EN ? 4'b0010 : 4'b0001, 2'b01, 1'b1, "pre_reset_window");
        push(242, 4'b0001, 2'b00, 1'b0, "async_reset");
        push(245, 4'b0001, 2'b00, 1'b0, "after_reset_245");
        push(252, 4'b0001, 2'b00, 1'b0, "after_reset_252");
        push(270, 4'b0001, 2'b00, 1'b0, "after_reset_270");
        goto(240); right = 1'b1;
        goto(241); right = 1'b0;
        goto(242); rst_n = 1'b0;
        goto(244); rst_n = 1'b1;

        goto(280);
        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
